// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
// Select encodings mirror the decode fields driven by the execute stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ASEL_ALU   = 2'b00,
    ASEL_STACK = 2'b01,
    ASEL_VEC0  = 2'b10,
    ASEL_VEC1  = 2'b11
  } addr_sel_e;

  typedef enum logic [1:0] {
    WSRC_RD1   = 2'b00,
    WSRC_PC    = 2'b01,
    WSRC_FLAGS = 2'b10,
    WSRC_ZERO  = 2'b11
  } wsrc_sel_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } ms_state_e;

  localparam int VEC0_ADDR = 0;
  localparam int VEC1_ADDR = 1;

endpackage

// File: rtl/memory_stage_data_memory.sv
// Single-port 16-bit data memory: write at the clock edge, combinational read.
// Contents are deliberately not reset.
module data_memory #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: loads/stores, stack pointer upkeep, and two-beat
// 32-bit PC push/pop; all results are registered toward write-back.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int          ADDR_W   = 11,
  parameter int unsigned SP_RESET = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       alu_result,
  input  logic [15:0]       read_data1,
  input  logic [31:0]       pc,
  input  logic [2:0]        flags,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_push,
  input  logic              mem_pop,
  input  logic              wide,
  input  logic [1:0]        memory_address_select,
  input  logic [1:0]        memory_write_src_select,
  input  logic              reg_write,
  input  logic [1:0]        wb_sel,
  output logic              stall,
  output logic [15:0]       mem_data_out,
  output logic [31:0]       mem_data32_out,
  output logic [15:0]       alu_result_out,
  output logic              reg_write_out,
  output logic [1:0]        wb_sel_out,
  output logic [ADDR_W-1:0] sp_out
);

  localparam logic [ADDR_W-1:0] SP_INIT = SP_RESET[ADDR_W-1:0];

  ms_state_e         state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       low_q;
  logic [15:0]       data_q;
  logic [31:0]       data32_q;
  logic [15:0]       alu_q;
  logic              rw_q;
  logic [1:0]        wb_q;

  logic              stack_any, push_op, pop_op, wide_op, beat1;
  logic [ADDR_W-1:0] sel_addr, mem_addr, sp_step;
  logic [15:0]       narrow_wdata, mem_wdata, mem_rdata, load_data;
  logic              mem_we;

  // Push and pop together cancel each other; wide only counts with a stack op.
  assign stack_any = mem_push | mem_pop;
  assign push_op   = mem_push & ~mem_pop;
  assign pop_op    = mem_pop & ~mem_push;
  assign wide_op   = wide & (push_op | pop_op);
  assign beat1     = (state_q == BEAT2);
  assign stall     = (state_q == IDLE) & wide_op;

  always_comb begin
    sel_addr = alu_result[ADDR_W-1:0];
    case (addr_sel_e'(memory_address_select))
      ASEL_ALU:   sel_addr = alu_result[ADDR_W-1:0];
      ASEL_STACK: sel_addr = sp_q;
      ASEL_VEC0:  sel_addr = ADDR_W'(VEC0_ADDR);
      ASEL_VEC1:  sel_addr = ADDR_W'(VEC1_ADDR);
      default:    sel_addr = alu_result[ADDR_W-1:0];
    endcase

    if (push_op)     mem_addr = beat1 ? sp_q - ADDR_W'(1) : sp_q;
    else if (pop_op) mem_addr = beat1 ? sp_q + ADDR_W'(2) : sp_q + ADDR_W'(1);
    else             mem_addr = sel_addr;
  end

  always_comb begin
    narrow_wdata = read_data1;
    case (wsrc_sel_e'(memory_write_src_select))
      WSRC_RD1:   narrow_wdata = read_data1;
      WSRC_PC:    narrow_wdata = pc[15:0];
      WSRC_FLAGS: narrow_wdata = {13'b0, flags};
      WSRC_ZERO:  narrow_wdata = 16'h0000;
      default:    narrow_wdata = read_data1;
    endcase
    // Wide push stores the high half first so it lands at the higher address.
    mem_wdata = wide_op ? (beat1 ? pc[15:0] : pc[31:16]) : narrow_wdata;
  end

  // Reset gates the write so a reset in BEAT2 abandons the second beat.
  assign mem_we    = ~reset & (push_op | (~stack_any & mem_write));
  assign load_data = (pop_op | (~stack_any & mem_read & ~mem_write)) ? mem_rdata : 16'h0000;

  always_comb begin
    sp_step = wide_op ? ADDR_W'(2) : ADDR_W'(1);
    sp_d    = sp_q;
    if (push_op & ~stall)     sp_d = sp_q - sp_step;
    else if (pop_op & ~stall) sp_d = sp_q + sp_step;

    state_d = IDLE;
    if (stall) state_d = BEAT2;
  end

  data_memory #(.ADDR_W(ADDR_W)) u_dmem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sp_q     <= SP_INIT;
      low_q    <= '0;
      data_q   <= '0;
      data32_q <= '0;
      alu_q    <= '0;
      rw_q     <= 1'b0;
      wb_q     <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      if (stall) begin
        // Bubble toward write-back; keep the low half of a wide pop.
        rw_q <= 1'b0;
        if (pop_op) low_q <= mem_rdata;
      end else begin
        data_q   <= load_data;
        data32_q <= (wide_op & pop_op) ? {mem_rdata, low_q} : {16'h0000, load_data};
        alu_q    <= alu_result;
        rw_q     <= reg_write;
        wb_q     <= wb_sel;
      end
    end
  end

  assign mem_data_out   = data_q;
  assign mem_data32_out = data32_q;
  assign alu_result_out = alu_q;
  assign reg_write_out  = rw_q;
  assign wb_sel_out     = wb_q;
  assign sp_out         = sp_q;

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth pipeline stage, sitting between the execute stage's output buffers and write-back. Performs data-memory loads and stores, and maintains the stack pointer for PUSH/POP. Handles 32-bit PC push/pop for CALL/RET/INT/RTI as a two-beat operation that stalls upstream. Registers all results and control for write-back.

## Interface
Parameters:
- ADDR_W, 11, word-address width of data memory (2^ADDR_W 16-bit words)
- SP_RESET, 2^ADDR_W-1, stack pointer value after reset

Ports:
- clk  in  1  stage clock
- reset  in  1  synchronous, active-high
- alu_result  in  16  effective address or ALU result from execute
- read_data1  in  16  store/push data (Rdst)
- pc  in  32  return PC for wide push
- flags  in  3  {C,N,Z} for flag push
- mem_read, mem_write, mem_push, mem_pop  in  1 each  memory commands
- wide  in  1  32-bit stack access (valid only with mem_push/mem_pop)
- memory_address_select  in  2  00 alu_result, 01 stack, 10 vector 0, 11 vector 1
- memory_write_src_select  in  2  00 read_data1, 01 pc, 10 {13'b0,flags}, 11 zero
- reg_write  in  1; wb_sel  in  2  write-back control, passed through
- stall  out  1  combinational; high during beat 0 of a wide access
- mem_data_out  out  16  registered load/pop data
- mem_data32_out  out  32  registered wide-pop data {high,low}
- alu_result_out  out  16; reg_write_out  out  1; wb_sel_out  out  2  registered pass-through
- sp_out  out  ADDR_W  current stack pointer (debug)

## Operation
- Addresses are truncated to the low ADDR_W bits. Vectors 0/1 are constant word addresses 0 and 1.
- Stack convention: SP points at the next free word, and the stack grows downward. SP arithmetic is modulo 2^ADDR_W (wrap silently).
- Narrow push: write M[SP], then SP-=1.
- Narrow pop: read M[SP+1], then SP+=1.
- Wide push: beat 0 writes pc[31:16] to M[SP]; beat 1 writes pc[15:0] to M[SP-1]; then SP-=2.
- Wide pop: beat 0 reads the low half from M[SP+1]; beat 1 reads the high half from M[SP+2]; then SP+=2. mem_data32_out = {high,low}.
- mem_read/mem_write use the selected address. The write source is set by memory_write_src_select; src 01 in a narrow access writes pc[15:0].
- wide without push/pop is ignored, and the access is performed narrow.
- Simultaneous commands:
  - mem_push & mem_pop both high: neither is performed, SP is unchanged, and mem_data_out=0.
  - mem_read & mem_write both high: the write is performed and mem_data_out=0.
- FSM states:
  - IDLE: a wide push/pop performs beat 0, asserts stall, and moves to BEAT2.
  - BEAT2: performs beat 1 with stall low, updates SP, and returns to IDLE.
- Upstream must hold all inputs stable while stall=1.
- Output registers:
  - On the stall cycle they load a bubble: reg_write_out=0 and the other outputs hold their values.
  - Otherwise they load this cycle's results.
- Memory contents are not reset.

## Timing
- Reset values: SP=SP_RESET, FSM=IDLE, stall=0, and every registered output = 0.
- Narrow access: data is visible on the outputs 1 cycle after the command cycle.
- Wide access: occupies 2 cycles. Results are visible after the BEAT2 edge, i.e. 2 cycles after the command first appears.
- Memory writes happen at the clock edge ending the beat. Reads are combinational from the array and captured at the same edge.
- SP updates at the edge ending the final beat, so a back-to-back stack op sees the updated SP.
- Reset asserted in BEAT2 abandons beat 1: the beat-0 write stays in memory, SP returns to SP_RESET, and the FSM goes to IDLE.

## Structure
- Package mem_stage_pkg holds:
  - enums addr_sel_e, wsrc_sel_e, ms_state_e (IDLE, BEAT2)
  - constants VEC0_ADDR=0, VEC1_ADDR=1
- Sub-module data_memory: single-port, 16-bit words, 2^ADDR_W deep, synchronous write, asynchronous read. It is instantiated once. SP, the FSM and the output registers live in memory_stage.

## Test plan
- Reset, then narrow push with read_data1=0xBEEF: M[0x7FF]=0xBEEF and SP=0x7FE. Next-cycle narrow pop: mem_data_out=0xBEEF and SP=0x7FF.
- Wide push with pc=0x0001_2345 at SP=0x7FF: stall is high for exactly one cycle; M[0x7FF]=0x0001, M[0x7FE]=0x2345, SP=0x7FD. A following wide pop gives mem_data32_out=0x0001_2345, SP=0x7FF, and reg_write_out=0 on the stall cycle.
- mem_write to alu_result=0x0010 with data 0x1234, then mem_read of 0x0010: mem_data_out=0x1234 one cycle later.
- Stack wrap: push at SP=0 writes M[0] and SP becomes 0x7FF. Push and pop together: SP is unchanged and mem_data_out=0.
- Reset asserted in BEAT2 of a wide push: M[SP_RESET] holds the high half, SP=0x7FF, stall=0, and all outputs are 0.
- Flag push (src 10, flags=3'b101): M[SP]=0x0005. Address select 11 with mem_read returns M[1].
